uart_tx_arbiter: RTL and testbench

//  Shares one UART byte transmitter among NUM_REQ requesters.
//  - Round-robin arbitration per message; a message is a byte sequence ending in req_last.
//  - Sequences the transmitter via a tx_start / tx_busy handshake.
//  - Sits between the command/status producers and the uart_tx core.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_arbiter_rr_picker.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    HOLD
  } arb_state_e;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int MAX_REQ         = 8;

  // Behavioural round-robin pick for up to MAX_REQ requesters; returns {found, idx}.
  function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int                 num_req);
    logic [3:0] res;
    logic [2:0] j;
    res = '0;
    for (int k = num_req - 1; k >= 0; k--) begin
      j = 3'((int'(ptr) + k) % num_req);
      if (valid[j]) res = {1'b1, j};
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin picker: rotate the request vector to start at i_ptr,
// priority-encode the lowest set bit, then rotate the index back.
module rr_picker
  import uart_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         i_valid,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic                       o_found,
  output logic [$clog2(NUM_REQ)-1:0] o_idx
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] w_rot;
  logic [IW-1:0]      w_off;

  always_comb begin
    w_rot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_rot[k] = i_valid[IW'((int'(i_ptr) + k) % NUM_REQ)];
    end
  end

  always_comb begin
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IW'(k);
    end
  end

  assign o_found = |w_rot;
  assign o_idx   = IW'((int'(i_ptr) + int'(w_off)) % NUM_REQ);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter among NUM_REQ requesters with per-message
// round-robin arbitration and a tx_start / tx_busy handshake.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = DEFAULT_NUM_REQ,
  parameter int BUSY_TIMEOUT = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*8-1:0]       i_req_data,
  input  logic [NUM_REQ-1:0]         i_req_last,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic                       o_tx_start,
  output logic [7:0]                 o_tx_data,
  input  logic                       i_tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_locked
);

  localparam int IW      = $clog2(NUM_REQ);
  localparam int CNT_MAX = (BUSY_TIMEOUT > LOCK_TIMEOUT) ? BUSY_TIMEOUT : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  arb_state_e r_state, w_state_nxt;
  logic [IW-1:0]    r_grant, w_grant_nxt;
  logic             r_locked, w_locked_nxt;
  logic [7:0]       r_tx_data, w_tx_data_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [IW-1:0]    w_ptr, w_idx;
  logic             w_found;

  assign w_ptr     = (r_grant == IW'(NUM_REQ - 1)) ? '0 : r_grant + IW'(1);
  assign w_cnt_inc = (r_cnt == CNT_W'(CNT_MAX)) ? r_cnt : r_cnt + CNT_W'(1);

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .i_valid (i_req_valid),
    .i_ptr   (w_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= IW'(NUM_REQ - 1);
      r_locked  <= 1'b0;
      r_tx_data <= 8'hFF;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_locked  <= w_locked_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_locked_nxt  = r_locked;
    w_tx_data_nxt = r_tx_data;
    w_cnt_nxt     = r_cnt;
    o_req_ready   = '0;
    o_tx_start    = 1'b0;
    case (r_state)
      IDLE: begin
        // A busy transmitter here belongs to a frame we did not launch.
        if (!i_tx_busy && |i_req_valid) w_state_nxt = ARB;
      end
      ARB: begin
        if (w_found) begin
          w_grant_nxt = w_idx;
          w_state_nxt = LAUNCH;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LAUNCH: begin
        o_req_ready[r_grant] = 1'b1;
        o_tx_start           = 1'b1;
        w_tx_data_nxt        = i_req_data[int'(r_grant)*8 +: 8];
        w_locked_nxt         = ~i_req_last[r_grant];
        w_cnt_nxt            = '0;
        w_state_nxt          = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        w_cnt_nxt = w_cnt_inc;
        if (i_tx_busy || r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) w_state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!i_tx_busy) begin
          if (!r_locked) begin
            w_state_nxt = ARB;
          end else if (i_req_valid[r_grant]) begin
            w_state_nxt = LAUNCH;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        w_cnt_nxt = w_cnt_inc;
        if (i_req_valid[r_grant]) begin
          w_state_nxt = LAUNCH;
        end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          w_locked_nxt = 1'b0;
          w_state_nxt  = ARB;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_tx_data  = r_tx_data;
  assign o_grant_id = r_grant;
  assign o_locked   = r_locked;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues feed the DUT, a
// scoreboard of expected launches is checked at every tx_start.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int BAUD  = 2;
  localparam int FRAME = 10 * BAUD;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           locked;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(16), .LOCK_TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .i_req_last  (req_last),
    .o_req_ready (req_ready),
    .o_tx_start  (tx_start),
    .o_tx_data   (tx_data),
    .i_tx_busy   (tx_busy),
    .o_grant_id  (grant_id),
    .o_locked    (locked)
  );

  typedef struct packed {
    logic [1:0]  id;
    logic [7:0]  data;
    logic        lock;
    logic [15:0] gap;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       pend;
  bit         pend_v = 0;
  logic [8:0] mem [N][16];
  int         wr[N];
  int         rd[N];
  int         ready_cnt[N];
  int         checks = 0, errors = 0;
  int         cyc = 0, launches = 0, last_launch = 0;
  bit         uart_en = 1;
  int         bcnt = 0;
  int         t_push;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input int id, input logic last, input logic [7:0] d, input int gap);
    exp_t e;
    mem[id][wr[id] % 16] = {last, d};
    wr[id]++;
    e.id   = 2'(id);
    e.data = d;
    e.lock = ~last;
    e.gap  = 16'(gap);
    exp_q.push_back(e);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rd[i] != wr[i]) begin
        req_valid[i]      = 1'b1;
        req_data[i*8 +: 8] = mem[i][rd[i] % 16][7:0];
        req_last[i]       = mem[i][rd[i] % 16][8];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"},    32'(req_ready), 32'h0);
    chk({tag, "_tx_start"}, 32'(tx_start),  32'h0);
    chk({tag, "_tx_data"},  32'(tx_data),   32'hFF);
    chk({tag, "_grant_id"}, 32'(grant_id),  32'h3);
    chk({tag, "_locked"},   32'(locked),    32'h0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset(tag);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || pend_v) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_pending_launches"}, 32'(exp_q.size()), 32'h0);
    repeat (30) @(negedge clk);
  endtask

  task automatic wait_launch(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (launches < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_launch_seen"}, 32'(launches >= target), 32'h1);
  endtask

  // Requester driver, uart_tx busy model and launch monitor, all in lockstep.
  initial begin
    logic [N-1:0] rdy;
    logic         st;
    exp_t         e;
    for (int i = 0; i < N; i++) begin
      wr[i] = 0; rd[i] = 0; ready_cnt[i] = 0;
    end
    req_data = '0;
    tx_busy  = 1'b0;
    drive();
    forever begin
      @(negedge clk);
      if (pend_v) begin
        chk("tx_data_after_launch", 32'(tx_data), 32'(pend.data));
        chk("locked_after_launch",  32'(locked),  32'(pend.lock));
        pend_v = 0;
      end
      if (tx_start) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_launch observed=grant%0d expected=no_launch", grant_id);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("launch_grant_id", 32'(grant_id),  32'(e.id));
          chk("launch_ready",    32'(req_ready), 32'(1) << e.id);
          chk("launch_while_busy", 32'(tx_busy), 32'h0);
          if (e.gap != 0) chk("launch_gap", 32'(cyc - last_launch), 32'(e.gap));
          pend   = e;
          pend_v = 1;
        end
        launches++;
        last_launch = cyc;
      end
      rdy = req_ready;
      st  = tx_start;
      for (int i = 0; i < N; i++) ready_cnt[i] += int'(rdy[i]);
      @(posedge clk);
      #1;
      cyc++;
      if (st && uart_en) bcnt = FRAME;
      else if (bcnt > 0) bcnt--;
      tx_busy = (bcnt != 0);
      for (int i = 0; i < N; i++) if (rdy[i]) rd[i]++;
      drive();
    end
  end

  initial begin
    do_reset("reset");

    // Single one-byte message.
    @(negedge clk);
    push_byte(0, 1'b1, 8'h41, 0);
    t_push = cyc;
    wait_drain("single", 400);
    chk("single_latency", 32'(last_launch - t_push), 32'd3);
    chk("single_ready_pulses", 32'(ready_cnt[0]), 32'd1);
    chk("single_locked_idle", 32'(locked), 32'h0);

    // All four requesters with one-byte messages; requester 0 has two.
    do_reset("reset2");
    @(negedge clk);
    push_byte(0, 1'b1, 8'hA0, 0);
    push_byte(1, 1'b1, 8'hB1, 23);
    push_byte(2, 1'b1, 8'hC2, 23);
    push_byte(3, 1'b1, 8'hD3, 23);
    push_byte(0, 1'b1, 8'hA4, 23);
    wait_drain("rr4", 600);

    // Three-byte message from requester 2 with 1 and 3 contending.
    @(negedge clk);
    push_byte(1, 1'b1, 8'h11, 0);
    push_byte(2, 1'b0, 8'h21, 23);
    push_byte(2, 1'b0, 8'h22, 22);
    push_byte(2, 1'b1, 8'h23, 22);
    push_byte(3, 1'b1, 8'h31, 23);
    push_byte(1, 1'b1, 8'h12, 23);
    wait_drain("locked_msg", 800);

    // Locked requester abandons its message; hold timeout releases the grant.
    @(negedge clk);
    push_byte(0, 1'b0, 8'h40, 0);
    push_byte(1, 1'b1, 8'h13, 31);
    wait_drain("hold_timeout", 400);
    chk("hold_locked_released", 32'(locked), 32'h0);

    // Transmitter never reports busy.
    uart_en = 0;
    @(negedge clk);
    push_byte(2, 1'b1, 8'h52, 0);
    push_byte(3, 1'b1, 8'h53, 19);
    wait_drain("busy_timeout", 400);
    uart_en = 1;

    // Reset while waiting for the frame of a locked message.
    @(negedge clk);
    push_byte(1, 1'b0, 8'h5A, 0);
    wait_launch("mid_reset", launches + 1, 100);
    repeat (4) @(negedge clk);
    chk("mid_reset_locked_before", 32'(locked), 32'h1);
    push_byte(0, 1'b1, 8'hC3, 0);
    push_byte(2, 1'b1, 8'h3C, 23);
    rst = 1'b1;
    @(negedge clk);
    check_reset("mid_reset");
    rst = 1'b0;
    wait_drain("after_reset", 400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
